// File: rtl/mem_access_stage.sv
// DLX MEM stage: byte/half/word loads and stores over a req/ack data port.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clock4,
    input  logic        reset4,
    input  logic [31:0] alu_in4,
    input  logic [31:0] bin4,
    input  logic [31:0] inst_in4,
    input  logic        mem_wr_en_in4,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        dmem_req,
    output logic        dmem_wr,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    output logic [31:0] alu_out4,
    output logic [31:0] lmd_out4,
    output logic [31:0] inst_out4,
    output logic        stall4,
    output logic        mem_err4
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [5:0] OP_LB  = 6'b000001;
    localparam logic [5:0] OP_LBU = 6'b000010;
    localparam logic [5:0] OP_LH  = 6'b000011;
    localparam logic [5:0] OP_LHU = 6'b000100;
    localparam logic [5:0] OP_LW  = 6'b000101;
    localparam logic [5:0] OP_SB  = 6'b001000;
    localparam logic [5:0] OP_SH  = 6'b001001;
    localparam logic [5:0] OP_SW  = 6'b001010;

    localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state, state_d;
    logic [7:0]  cnt, cnt_d;
    logic [5:0]  op_q, op_d;
    logic [1:0]  lo_q, lo_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] adr_q, adr_d;

    logic        req_d, wr_d, err_d;
    logic [31:0] addr_d, wdata_d, alu_d, lmd_d, inst_d;
    logic [3:0]  be_d;

    logic [5:0]  opc;
    logic        is_load, is_store, is_mem;
    logic        sz_b, sz_h, sz_w, misal, trap;
    logic [1:0]  lo;
    logic [3:0]  be_in;
    logic [31:0] wd_in;
    logic        q_load;

    assign opc = inst_in4[31:26];

    always_comb begin
        is_load  = opc inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
        is_store = (opc inside {OP_SB, OP_SH, OP_SW}) && mem_wr_en_in4;
        is_mem   = is_load || is_store;
        sz_b     = opc inside {OP_LB, OP_LBU, OP_SB};
        sz_h     = opc inside {OP_LH, OP_LHU, OP_SH};
        sz_w     = opc inside {OP_LW, OP_SW};
        misal    = (sz_h && alu_in4[0]) || (sz_w && (alu_in4[1:0] != 2'b00));
    end

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = is_mem && misal;
    assign lo   = alu_in4[1:0];
`else
    // Offending low bits are dropped so the access stays naturally aligned
    assign trap = 1'b0;
    assign lo   = sz_w ? 2'b00 :
                  sz_h ? {alu_in4[1], 1'b0} :
                  alu_in4[1:0];
`endif

    always_comb begin
        be_in = 4'b1111;
        wd_in = bin4;
        unique case (1'b1)
            sz_b: begin
                be_in = 4'b0001 << lo;
                wd_in = bin4 << {lo, 3'b000};
            end
            sz_h: begin
                be_in = lo[1] ? 4'b1100 : 4'b0011;
                wd_in = bin4 << {lo[1], 4'b0000};
            end
            default: begin
                be_in = 4'b1111;
                wd_in = bin4;
            end
        endcase
    end

    function automatic logic [31:0] fmt(
        input logic [5:0]  op,
        input logic [1:0]  sel,
        input logic [31:0] d
    );
        logic [31:0] sh;
        logic [15:0] h;
        sh = d >> {sel, 3'b000};
        h  = sel[1] ? d[31:16] : d[15:0];
        case (op)
            OP_LB:   fmt = {{24{sh[7]}}, sh[7:0]};
            OP_LBU:  fmt = {24'h0, sh[7:0]};
            OP_LH:   fmt = {{16{h[15]}}, h};
            OP_LHU:  fmt = {16'h0, h};
            default: fmt = d;
        endcase
    endfunction

    assign q_load = op_q inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        op_d    = op_q;
        lo_d    = lo_q;
        ir_d    = ir_q;
        adr_d   = adr_q;
        req_d   = dmem_req;
        wr_d    = dmem_wr;
        addr_d  = dmem_addr;
        be_d    = dmem_be;
        wdata_d = dmem_wdata;
        alu_d   = alu_out4;
        lmd_d   = lmd_out4;
        inst_d  = inst_out4;
        err_d   = 1'b0;
        stall4  = 1'b0;
        unique case (state)
            IDLE: begin
                if (trap) begin
                    inst_d = 32'h0;
                    err_d  = 1'b1;
                end else if (is_mem) begin
                    stall4  = 1'b1;
                    state_d = BUSY;
                    cnt_d   = 8'd0;
                    op_d    = opc;
                    lo_d    = lo;
                    ir_d    = inst_in4;
                    adr_d   = alu_in4;
                    req_d   = 1'b1;
                    wr_d    = is_store;
                    addr_d  = {alu_in4[31:2], 2'b00};
                    be_d    = be_in;
                    wdata_d = wd_in;
                    inst_d  = 32'h0;
                end else begin
                    alu_d  = alu_in4;
                    inst_d = inst_in4;
                end
            end
            BUSY: begin
                if (dmem_ack) begin
                    // Release the stall now so EX advances past this op
                    state_d = IDLE;
                    req_d   = 1'b0;
                    wr_d    = 1'b0;
                    inst_d  = ir_q;
                    alu_d   = adr_q;
                    if (q_load) lmd_d = fmt(op_q, lo_q, dmem_rdata);
                end else begin
                    stall4 = 1'b1;
                    if (cnt == LAST) begin
                        state_d = IDLE;
                        cnt_d   = 8'd0;
                        req_d   = 1'b0;
                        wr_d    = 1'b0;
                        err_d   = 1'b1;
                        inst_d  = 32'h0;
                    end else begin
                        cnt_d = cnt + 8'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock4 or posedge reset4) begin
        if (reset4) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            op_q       <= 6'd0;
            lo_q       <= 2'd0;
            ir_q       <= 32'h0;
            adr_q      <= 32'h0;
            dmem_req   <= 1'b0;
            dmem_wr    <= 1'b0;
            dmem_addr  <= 32'h0;
            dmem_be    <= 4'h0;
            dmem_wdata <= 32'h0;
            alu_out4   <= 32'h0;
            lmd_out4   <= 32'h0;
            inst_out4  <= 32'h0;
            mem_err4   <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            op_q       <= op_d;
            lo_q       <= lo_d;
            ir_q       <= ir_d;
            adr_q      <= adr_d;
            dmem_req   <= req_d;
            dmem_wr    <= wr_d;
            dmem_addr  <= addr_d;
            dmem_be    <= be_d;
            dmem_wdata <= wdata_d;
            alu_out4   <= alu_d;
            lmd_out4   <= lmd_d;
            inst_out4  <= inst_d;
            mem_err4   <= err_d;
        end
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- DLX pipeline stage 4 (MEM). Consumes the EX stage register outputs: ALU result/address, store data, instruction register and memory write enable.
- Performs byte/half/word loads and stores against a variable-latency data memory using a req/ack handshake.
- Returns a formatted load data register (LMD) plus pass-through ALU result and IR to write-back.
- Stalls upstream stages while an access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 16, number of BUSY cycles without dmem_ack before the access is aborted; legal range 1..255.

Ports:
- clock4  input  1  stage clock, rising edge.
- reset4  input  1  asynchronous, active-high reset.
- alu_in4  input  32  ALU result from EX; byte address for loads/stores.
- bin4  input  32  store data from EX, already zero-extended in the low bits.
- inst_in4  input  32  IR from EX; opcode is bits [31:26].
- mem_wr_en_in4  input  1  EX store qualifier; a store is performed only when this is 1.
- dmem_rdata  input  32  read data from data memory.
- dmem_ack  input  1  memory completion, 1-cycle pulse.
- dmem_req  output  1  access request, held until ack or abort.
- dmem_wr  output  1  1 = write, 0 = read; valid while dmem_req is high.
- dmem_addr  output  32  word-aligned address, {addr[31:2],2'b00}.
- dmem_be  output  4  byte-lane enables.
- dmem_wdata  output  32  store data shifted onto its lane.
- alu_out4  output  32  ALU result to write-back.
- lmd_out4  output  32  formatted load data.
- inst_out4  output  32  IR to write-back; 0 (NOP) denotes a bubble.
- stall4  output  1  combinational hold request to IF/ID/EX.
- mem_err4  output  1  1-cycle pulse on timeout or misalignment abort.

Behaviour:
- Reset: every registered output is 0 (dmem_req, dmem_wr, dmem_addr, dmem_be, dmem_wdata, alu_out4, lmd_out4, inst_out4, mem_err4). State goes to IDLE and the timeout counter to 0. Reset mid-access drops dmem_req immediately; a late ack arriving in IDLE is ignored.
- Memory op definition: opcode is one of LB=000001, LBU=000010, LH=000011, LHU=000100, LW=000101, or one of SB=001000, SH=001001, SW=001010 with mem_wr_en_in4=1. A store opcode with mem_wr_en_in4=0 is treated as a non-memory op.
- Little-endian lanes: byte n = bits [8n+7:8n], where n = addr[1:0].
  - Byte access: be = 1<<addr[1:0].
  - Half access: be = 0011 if addr[1]=0, else 1100.
  - Word access: be = 1111.
  - wdata = bin4 shifted left by 8*addr[1:0] for byte, by 16*addr[1] for half.
- FSM states: IDLE, BUSY.
- IDLE, non-memory op:
  - At the edge: alu_out4<=alu_in4, inst_out4<=inst_in4, lmd_out4 holds.
  - stall4=0; latency 1 cycle.
- IDLE, memory op:
  - stall4=1 combinationally.
  - At the edge: latch opcode and addr[1:0], drive dmem_req=1 with addr/be/wdata/wr, inst_out4<=0 (bubble), counter<=0, go to BUSY.
- BUSY without ack:
  - stall4=1; inputs are ignored; counter increments.
  - When counter reaches TIMEOUT_CYCLES-1: dmem_req<=0, mem_err4<=1 for one cycle, inst_out4<=0, go to IDLE.
- BUSY with ack:
  - stall4=0 in that same cycle, so EX advances on this edge. This prevents re-accepting the same instruction.
  - At the edge: dmem_req<=0, inst_out4<=latched IR, alu_out4<=latched address, go to IDLE.
  - For loads, lmd_out4<=formatted dmem_rdata:
    - LB: sign-extend the selected byte.
    - LBU: zero-extend the selected byte.
    - LH: sign-extend the selected half.
    - LHU: zero-extend the selected half.
    - LW: full word.
  - For stores, lmd_out4 holds.
- Minimum memory-op latency is 2 cycles (ack in the first BUSY cycle). Each extra wait cycle adds 1.
- Timeout and ack in the same cycle: ack wins, no error.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined: a half access with addr[0]=1 or a word access with addr[1:0]!=0 performs no memory request. At the IDLE edge: mem_err4<=1 for one pulse, inst_out4<=0, stall4=0.
- Undefined: offending low address bits are forced to 0 (half: addr[0]; word: addr[1:0]) and the access proceeds normally. mem_err4 then pulses only on timeout.

Test Plan:
- Reset asserted mid-BUSY → dmem_req drops without waiting for the clock; all outputs are 0. A subsequent ack is ignored and the state stays IDLE.
- ADDI IR, alu_in4=0x00000010 → next cycle alu_out4=0x10 and inst_out4=IR, with stall4 low throughout.
- LB at addr 0x103, ack after 3 BUSY cycles, dmem_rdata=0x80FF_FFFF:
  - dmem_addr=0x100, be=1000.
  - stall4 high for 4 cycles.
  - lmd_out4=0xFFFFFF80.
  - The same access as LBU gives 0x00000080.
- SH at addr 0x202, bin4=0x0000BEEF, mem_wr_en_in4=1 → dmem_wr=1, be=1100, wdata=0xBEEF0000. The same opcode with mem_wr_en_in4=0 passes through with no dmem_req.
- LW at addr 0x40 with no ack and TIMEOUT_CYCLES=4 → dmem_req high for 4 cycles, then a single mem_err4 pulse, inst_out4=0, and stall4 released.
- LW at addr 0x42:
  - With MEM_MISALIGN_TRAP_EN: no dmem_req, one mem_err4 pulse.
  - Without it: dmem_addr=0x40, be=1111, normal completion.
